// File: rtl/axis_pkg.sv
// ---------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-Stream demultiplexer:
//   AXIS_DATA_W_DEF : default tdata width
//   demux_state_t   : packet-routing FSM state (idle / inside a packet)
//   dest_t          : output port index (0 or 1)
// ---------------------------------------------------------------------------
package axis_pkg;

    localparam int AXIS_DATA_W_DEF = 8;

    typedef enum logic {
        ST_IDLE,
        ST_PKT
    } demux_state_t;

    typedef logic dest_t;

endpackage

// File: rtl/axis_demux_oreg.sv
// ---------------------------------------------------------------------------
// axis_demux_oreg
// Single-entry output holding register (valid / data / last / dest).
// A load takes priority over a drain, so a simultaneous load and drain
// replaces the contents with no bubble.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   load_i               : capture data_i/last_i/dest_i and set valid
//   drain_i              : current entry was consumed downstream
//   data_i, last_i, dest_i : beat to capture
//   vld_o, data_o, last_o, dest_o : registered entry
// ---------------------------------------------------------------------------
module axis_demux_oreg
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  dest_t             dest_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o,
    output logic              last_o,
    output dest_t             dest_o
);

    logic              vld_q,  vld_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              last_q, last_d;
    dest_t             dest_q, dest_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        last_d = last_q;
        dest_d = dest_q;
        if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
            last_d = last_i;
            dest_d = dest_i;
        end else if (drain_i) begin
            vld_d  = 1'b0;
        end
    end

    // Data fields are reset as well so every m_axis_* output reads 0 in reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q  <= 1'b0;
            data_q <= '0;
            last_q <= 1'b0;
            dest_q <= 1'b0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
            last_q <= last_d;
            dest_q <= dest_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;
    assign last_o = last_q;
    assign dest_o = dest_q;

endmodule

// File: rtl/axis_demux.sv
// ---------------------------------------------------------------------------
// axis_demux
// 1:2 AXI-Stream demultiplexer. Whole packets are routed to master port 0
// or 1; the route is taken from sel on a packet's first beat and locked
// until its tlast beat. Output is a one-entry register with full-throughput
// backpressure (s_axis_tready depends only on downstream ready).
//
// Optional feature (macro AXIS_DEMUX_PKTCNT_EN): per-port packet counters
// pkt_cnt_0 / pkt_cnt_1 (CNT_W bits, wrapping) counting transferred tlast beats.
//
// Ports:
//   aclk, aresetn                    : clock, asynchronous active-low reset
//   s_axis_tdata/tvalid/tlast/tready : slave stream
//   sel                              : destination for a new packet
//   m_axis_tdata/tvalid/tlast/tready_0 : master port 0
//   m_axis_tdata/tvalid/tlast/tready_1 : master port 1
//   pkt_cnt_0, pkt_cnt_1             : packet counters (optional)
// ---------------------------------------------------------------------------
module axis_demux
    import axis_pkg::*;
#(
    parameter int DATA_W = AXIS_DATA_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    input  logic              sel,
    output logic [DATA_W-1:0] m_axis_tdata_0,
    output logic              m_axis_tvalid_0,
    output logic              m_axis_tlast_0,
    input  logic              m_axis_tready_0,
    output logic [DATA_W-1:0] m_axis_tdata_1,
    output logic              m_axis_tvalid_1,
    output logic              m_axis_tlast_1,
    input  logic              m_axis_tready_1
`ifdef AXIS_DEMUX_PKTCNT_EN
    ,
    output logic [CNT_W-1:0]  pkt_cnt_0,
    output logic [CNT_W-1:0]  pkt_cnt_1
`endif
);

    demux_state_t      state_q, state_d;
    dest_t             route_q, route_d;
    dest_t             load_dest;

    logic              out_vld;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    dest_t             out_dest;

    logic              dst_rdy;
    logic              acc;
    logic              xfer;

    // Ready of whichever port the held beat is destined for; the other
    // port's ready is irrelevant.
    assign dst_rdy       = (out_dest == 1'b1) ? m_axis_tready_1 : m_axis_tready_0;
    assign s_axis_tready = aresetn && (!out_vld || dst_rdy);
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign xfer          = out_vld && dst_rdy;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            route_q <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        route_d   = route_q;
        load_dest = route_q;
        case (state_q)
            ST_IDLE: begin
                load_dest = sel;
                // Single-beat packets never leave IDLE.
                if (acc && !s_axis_tlast) begin
                    route_d = sel;
                    state_d = ST_PKT;
                end
            end
            ST_PKT: begin
                load_dest = route_q;
                if (acc && s_axis_tlast) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    axis_demux_oreg #(
        .DATA_W (DATA_W)
    ) u_oreg (
        .clk_i   (aclk),
        .rst_ni  (aresetn),
        .load_i  (acc),
        .drain_i (xfer),
        .data_i  (s_axis_tdata),
        .last_i  (s_axis_tlast),
        .dest_i  (load_dest),
        .vld_o   (out_vld),
        .data_o  (out_data),
        .last_o  (out_last),
        .dest_o  (out_dest)
    );

    assign m_axis_tvalid_0 = out_vld && (out_dest == 1'b0);
    assign m_axis_tvalid_1 = out_vld && (out_dest == 1'b1);
    assign m_axis_tdata_0  = (out_dest == 1'b0) ? out_data : '0;
    assign m_axis_tdata_1  = (out_dest == 1'b1) ? out_data : '0;
    assign m_axis_tlast_0  = (out_dest == 1'b0) ? out_last : 1'b0;
    assign m_axis_tlast_1  = (out_dest == 1'b1) ? out_last : 1'b0;

`ifdef AXIS_DEMUX_PKTCNT_EN
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (xfer && out_last) begin
            if (out_dest == 1'b0) begin
                cnt0_d = cnt0_q + 1'b1;
            end else begin
                cnt1_d = cnt1_q + 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign pkt_cnt_0 = cnt0_q;
    assign pkt_cnt_1 = cnt1_q;
`endif

endmodule

// File: tb/tb_axis_demux.sv
module tb_axis_demux;

    localparam int DW = 8;
    localparam int CW = 2;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid, s_tlast, s_tready, sel;
    logic [DW-1:0] tdata0, tdata1;
    logic          tvalid0, tvalid1, tlast0, tlast1;
    logic          rdy0, rdy1;
`ifdef AXIS_DEMUX_PKTCNT_EN
    logic [CW-1:0] pkt_cnt_0, pkt_cnt_1;
`endif

    always #5 aclk = ~aclk;

    axis_demux #(.DATA_W(DW), .CNT_W(CW)) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .s_axis_tdata    (s_tdata),
        .s_axis_tvalid   (s_tvalid),
        .s_axis_tlast    (s_tlast),
        .s_axis_tready   (s_tready),
        .sel             (sel),
        .m_axis_tdata_0  (tdata0),
        .m_axis_tvalid_0 (tvalid0),
        .m_axis_tlast_0  (tlast0),
        .m_axis_tready_0 (rdy0),
        .m_axis_tdata_1  (tdata1),
        .m_axis_tvalid_1 (tvalid1),
        .m_axis_tlast_1  (tlast1),
        .m_axis_tready_1 (rdy1)
`ifdef AXIS_DEMUX_PKTCNT_EN
        ,
        .pkt_cnt_0       (pkt_cnt_0),
        .pkt_cnt_1       (pkt_cnt_1)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Expected beats per port as {last, data}; a packet-level view of routing.
    typedef struct { logic last; logic [DW-1:0] data; } beat_t;
    typedef struct { int c; bit port; bit last; logic [DW-1:0] data; } ev_t;
    beat_t q0[$];
    beat_t q1[$];
    ev_t   evlog[$];
    bit    in_pkt = 0;
    bit    route  = 0;
    int    cnt0   = 0;
    int    cnt1   = 0;

    always @(negedge aclk) begin
        bit    exp_rdy;
        bit    d;
        beat_t b;
        cyc++;
        if (!aresetn) begin
            chk("rst_s_tready", s_tready, 0);
            chk("rst_tvalid0", tvalid0, 0);
            chk("rst_tvalid1", tvalid1, 0);
            chk("rst_tdata0", tdata0, 0);
            chk("rst_tdata1", tdata1, 0);
            chk("rst_tlast0", tlast0, 0);
            chk("rst_tlast1", tlast1, 0);
            q0.delete();
            q1.delete();
            in_pkt = 0;
            route  = 0;
            cnt0   = 0;
            cnt1   = 0;
        end else begin
            chk("tvalid0", tvalid0, q0.size() != 0);
            chk("tvalid1", tvalid1, q1.size() != 0);
            if (q0.size() != 0) begin
                chk("tdata0", tdata0, q0[0].data);
                chk("tlast0", tlast0, q0[0].last);
                chk("tdata1_idle", tdata1, 0);
            end
            if (q1.size() != 0) begin
                chk("tdata1", tdata1, q1[0].data);
                chk("tlast1", tlast1, q1[0].last);
                chk("tdata0_idle", tdata0, 0);
            end
            exp_rdy = (q0.size() == 0 && q1.size() == 0) ||
                      (q0.size() != 0 && rdy0) || (q1.size() != 0 && rdy1);
            chk("s_tready", s_tready, exp_rdy);
`ifdef AXIS_DEMUX_PKTCNT_EN
            chk("pkt_cnt_0", pkt_cnt_0, cnt0 % 4);
            chk("pkt_cnt_1", pkt_cnt_1, cnt1 % 4);
`endif
            // Transfers happening at the coming edge.
            if (q0.size() != 0 && rdy0) begin
                b = q0.pop_front();
                if (b.last) cnt0++;
                evlog.push_back('{cyc, 1'b0, b.last, b.data});
            end
            if (q1.size() != 0 && rdy1) begin
                b = q1.pop_front();
                if (b.last) cnt1++;
                evlog.push_back('{cyc, 1'b1, b.last, b.data});
            end
            if (s_tvalid && exp_rdy) begin
                d = in_pkt ? route : sel;
                if (!in_pkt && !s_tlast) begin
                    in_pkt = 1;
                    route  = sel;
                end else if (in_pkt && s_tlast) begin
                    in_pkt = 0;
                end
                if (d) q1.push_back('{s_tlast, s_tdata});
                else   q0.push_back('{s_tlast, s_tdata});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [DW-1:0] dat, input logic lst, input logic sl);
        int t;
        t = 0;
        s_tdata  = dat;
        s_tlast  = lst;
        sel      = sl;
        s_tvalid = 1'b1;
        forever begin
            @(negedge aclk);
            if (s_tready) break;
            t++;
            if (t > 100) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge aclk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic chk_ev(input string name, input int idx, input bit port,
                          input bit last, input logic [DW-1:0] data);
        if (idx >= evlog.size()) begin
            chk({name, "_missing"}, evlog.size(), idx + 1);
        end else begin
            chk({name, "_port"}, evlog[idx].port, port);
            chk({name, "_last"}, evlog[idx].last, last);
            chk({name, "_data"}, evlog[idx].data, data);
        end
    endtask

    initial begin
        bit acc_seen;
        aresetn  = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = 8'h3C;
        s_tlast  = 1'b0;
        sel      = 1'b0;
        rdy0     = 1'b1;
        rdy1     = 1'b1;
        idle(3);
        s_tvalid = 1'b0;
        aresetn  = 1'b1;
        idle(1);

        // Single-beat packet to port 0, visible the cycle after acceptance.
        send(8'hA5, 1'b1, 1'b0);
        @(negedge aclk);
        chk("first_tvalid0", tvalid0, 1);
        chk("first_tdata0", tdata0, 8'hA5);
        chk("first_tlast0", tlast0, 1);
        chk("first_tvalid1", tvalid1, 0);
        idle(3);

        // Route lock: sel changes after the first beat are ignored.
        evlog.delete();
        send(8'h10, 1'b0, 1'b1);
        send(8'h11, 1'b0, 1'b0);
        send(8'h12, 1'b0, 1'b0);
        send(8'h13, 1'b1, 1'b0);
        send(8'h14, 1'b1, 1'b0);   // new packet: sel honoured again
        idle(4);
        chk("lock_count", evlog.size(), 5);
        chk_ev("lock0", 0, 1'b1, 1'b0, 8'h10);
        chk_ev("lock1", 1, 1'b1, 1'b0, 8'h11);
        chk_ev("lock2", 2, 1'b1, 1'b0, 8'h12);
        chk_ev("lock3", 3, 1'b1, 1'b1, 8'h13);
        chk_ev("lock4", 4, 1'b0, 1'b1, 8'h14);

        // Back-to-back packets to alternating ports, no bubble.
        evlog.delete();
        send(8'h20, 1'b0, 1'b0);
        send(8'h21, 1'b1, 1'b0);
        send(8'h30, 1'b0, 1'b1);
        send(8'h31, 1'b1, 1'b1);
        idle(4);
        chk_ev("b2b0", 0, 1'b0, 1'b0, 8'h20);
        chk_ev("b2b1", 1, 1'b0, 1'b1, 8'h21);
        chk_ev("b2b2", 2, 1'b1, 1'b0, 8'h30);
        chk_ev("b2b3", 3, 1'b1, 1'b1, 8'h31);
        if (evlog.size() >= 4) chk("b2b_gapless", evlog[3].c - evlog[0].c, 3);

        // Backpressure on port 1 mid-packet; port 0 ready wiggles uselessly.
        send(8'h40, 1'b0, 1'b1);
        send(8'h41, 1'b0, 1'b0);
        rdy1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rdy0 = i[0];
            @(negedge aclk);
            chk("bp_s_tready", s_tready, 0);
            chk("bp_tvalid1", tvalid1, 1);
            chk("bp_tdata1", tdata1, 8'h41);
            @(posedge aclk);
            #1;
        end
        rdy1 = 1'b1;
        rdy0 = 1'b1;
        send(8'h42, 1'b0, 1'b0);
        send(8'h43, 1'b1, 1'b0);
        idle(3);

        // Reset mid-packet, then a fresh packet chooses its own route.
        send(8'h50, 1'b0, 1'b1);
        send(8'h51, 1'b0, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("mid_rst_tvalid1", tvalid1, 0);
        chk("mid_rst_tdata1", tdata1, 0);
        idle(2);
        aresetn = 1'b1;
        idle(1);
        evlog.delete();
        send(8'h60, 1'b1, 1'b0);
        idle(3);
        chk("post_rst_count", evlog.size(), 1);
        chk_ev("post_rst", 0, 1'b0, 1'b1, 8'h60);

`ifdef AXIS_DEMUX_PKTCNT_EN
        // 2-bit counters wrap after 3.
        aresetn = 1'b0;
        idle(2);
        aresetn = 1'b1;
        idle(1);
        for (int i = 0; i < 5; i++) begin
            send(8'h70 + 8'(i), 1'b1, 1'b0);
            @(negedge aclk);
            @(negedge aclk);
            chk("cnt0_lit", pkt_cnt_0, (i + 1) % 4);
            chk("cnt1_lit", pkt_cnt_1, 0);
            @(posedge aclk);
            #1;
        end
`endif

        // Randomized traffic with random downstream backpressure.
        s_tvalid = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge aclk);
            acc_seen = s_tvalid && s_tready;
            @(posedge aclk);
            #1;
            if (!s_tvalid || acc_seen) begin
                s_tvalid = ($urandom_range(0, 3) != 0);
                s_tdata  = DW'($urandom);
                s_tlast  = ($urandom_range(0, 3) == 0);
                sel      = 1'($urandom);
            end
            rdy0 = ($urandom_range(0, 3) != 0);
            rdy1 = ($urandom_range(0, 3) != 0);
        end
        s_tvalid = 1'b0;
        rdy0     = 1'b1;
        rdy1     = 1'b1;
        idle(5);
        chk("drain_q0", q0.size(), 0);
        chk("drain_q1", q1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
